nexus_share_filter: RTL
=======================

# nexus_share_filter

Downstream of the SK1024 hash pipeline: FirstSkeinRound → SecondSkeinRound → NexusKeccak1024. The block consumes the 64-bit Keccak output qword every cycle and reconstructs which nonce produced it, tracking pipeline fill after each work load. It compares that qword against a programmable 64-bit target and queues winning nonces in a small FIFO. The FIFO drains to the host/miner interface through a valid/ready handshake.

## Interface
Parameters:
- `PIPE_LATENCY`, default 388: cycles from a nonce entering FirstSkeinRound to its qword at the Keccak output. Default is 2×122 Skein + 3×48 Keccak.
- `FIFO_DEPTH`, default 8: hit FIFO entries; power of two, ≥2.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `nHashRst`, input, 1: asynchronous, active-low reset.
- `work_load`, input, 1: one-cycle strobe; new work, base nonce on `work_nonce`.
- `work_nonce`, input, 64: nonce fed to the pipeline on the cycle after `work_load` is sampled.
- `target`, input, 64: share target; hit when qword ≤ target (unsigned). Quasi-static; sampled at `work_load`.
- `hash_qword`, input, 64: KeccakOutputQword, valid every cycle once filled.
- `nonce_out`, output, 64: head-of-FIFO winning nonce.
- `nonce_valid`, output, 1: FIFO non-empty.
- `nonce_ready`, input, 1: consumer accepts head when `nonce_valid & nonce_ready`.
- `busy`, output, 1: high while in FILL.
- `overflow`, output, 1: sticky; a hit was dropped because the FIFO was full.
- `hit_count`, output, 32: saturating count of hits accepted since last `work_load`.

## Operation
- States: IDLE → FILL → CHECK.
- IDLE (reset state): `hash_qword` ignored; no hits.
- `work_load` from any state:
  - latches `work_nonce` into `cur_nonce` and `target` into `tgt_q`;
  - clears `fill_cnt`, FIFO pointers, `overflow` and `hit_count`;
  - enters FILL.
- FILL:
  - `fill_cnt` increments each cycle.
  - When `fill_cnt == PIPE_LATENCY-1`, the next state is CHECK.
- CHECK, every cycle:
  - hit = (`hash_qword` ≤ `tgt_q`).
  - On a hit, push `cur_nonce` if the FIFO is not full; otherwise drop it and set `overflow`.
  - `cur_nonce` increments by 1 (mod 2^64, wraps silently).
- Accepted hit: `hit_count` += 1, saturating at 0xFFFFFFFF.
- Full FIFO with simultaneous pop and push: both occur; no overflow.
- `work_load` coincident with a hit: load wins; the hit is discarded and the FIFO flushed (stale work).
- `work_load` during FILL restarts the fill count from 0.
- Target equal to 0xFFFFFFFFFFFFFFFF: every CHECK cycle is a hit.

## Timing
- Reset values:
  - `nonce_out` = 0;
  - `nonce_valid` = 0, `busy` = 0, `overflow` = 0;
  - `hit_count` = 0;
  - state = IDLE.
- Let `work_load` be sampled at edge E0. The qword sampled at edge E0+PIPE_LATENCY+1 belongs to `work_nonce`; each later edge is +1.
- Hit at edge E: the FIFO write occurs at E. `nonce_valid` rises after E if the FIFO was empty, i.e. 1-cycle hit-to-valid latency.
- `nonce_out` is registered from the FIFO head and stable while `nonce_valid & !nonce_ready`.
- `busy` is high from E0+1 through the last FILL cycle.
- Async reset assertion immediately clears all state, FIFO included. Deassertion is expected synchronous to `clk` (external synchronizer).

## Structure
- Package `nexus_pkg` holds:
  - stage constants: SKEIN_RND_STAGES=4, SKEIN_KEY_STAGES=2, SKEIN_ROUNDS=20, SKEIN_KEY_INJ=21, KECCAK_RND_STAGES=2, KECCAK_ROUNDS=24;
  - the derived `PIPE_LATENCY_DEFAULT`;
  - the state enum `filt_state_t` {IDLE, FILL, CHECK};
  - `nonce_t` (64-bit).
- Sub-module `share_fifo` (parameterised width/depth, sync flush, full/empty, registered head). It is reusable for the future pool-share path.
- The top module holds the FSM, fill counter, nonce counter and comparator.

## Test plan
- Reset: hold `nHashRst`=0 with `hash_qword`=0 → all outputs 0, state IDLE, no push.
- Basic hit:
  - load `work_nonce`=0x00000001FCAFC044, `target`=0x00000000FFFFFFFF;
  - drive qword 0xFFFFFFFFFFFFFFFF except 0x0000000012345678 at edge E0+389+5;
  - → exactly one `nonce_out`=0x00000001FCAFC049, `busy` low from E0+389.
- Overflow: target all-ones, `nonce_ready`=0 for 12 CHECK cycles → 8 entries `base`..`base+7`, `overflow`=1, `hit_count`=8. Then drain with `nonce_ready`=1 → 8 pops in order.
- Full pop+push: FIFO full, `nonce_ready`=1, hit every cycle → no overflow, order preserved.
- Reload mid-CHECK with 3 queued hits: `work_load` coincident with a hit → FIFO empty, `hit_count`=0, `overflow`=0, `busy`=1 next cycle.
- Nonce wrap: `work_nonce`=0xFFFFFFFFFFFFFFFE, hits on the first 3 CHECK cycles → 0xFFFFFFFFFFFFFFFE, 0xFFFFFFFFFFFFFFFF, 0x0000000000000000.

Source files
------------

// File: rtl/nexus_pkg.sv
// nexus_pkg: shared constants and types for the SK1024 share filter.
//   - Stage constants of the upstream Skein/Keccak pipeline and the derived default
//     pipeline latency (nonce in -> Keccak output qword).
//   - filt_state_t: share filter FSM states.
//   - nonce_t: 64-bit nonce.
package nexus_pkg;

    localparam int unsigned SKEIN_RND_STAGES  = 4;
    localparam int unsigned SKEIN_KEY_STAGES  = 2;
    localparam int unsigned SKEIN_ROUNDS      = 20;
    localparam int unsigned SKEIN_KEY_INJ     = 21;
    localparam int unsigned KECCAK_RND_STAGES = 2;
    localparam int unsigned KECCAK_ROUNDS     = 24;

    // One Skein block: 20 rounds x 4 stages + 21 key injections x 2 stages = 122 cycles.
    localparam int unsigned SKEIN_LATENCY =
        SKEIN_ROUNDS * SKEIN_RND_STAGES + SKEIN_KEY_INJ * SKEIN_KEY_STAGES;
    // One Keccak permutation: 24 rounds x 2 stages = 48 cycles.
    localparam int unsigned KECCAK_LATENCY = KECCAK_ROUNDS * KECCAK_RND_STAGES;

    // Two Skein blocks followed by three Keccak permutations: 388 cycles.
    localparam int unsigned PIPE_LATENCY_DEFAULT = 2 * SKEIN_LATENCY + 3 * KECCAK_LATENCY;

    typedef logic [63:0] nonce_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CHECK
    } filt_state_t;

endpackage

// File: rtl/share_fifo.sv
// share_fifo: small synchronous FIFO with a registered head word.
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset, clears everything
//   flush_i    - synchronous flush; empties the FIFO, overrides push and pop
//   push_i     - write request for wdata_i
//   wdata_i    - data to write
//   pop_i      - consumer accepts the head (ignored while empty)
//   rdata_o    - head of the FIFO (registered)
//   valid_o    - FIFO non-empty
//   accept_o   - push_i was taken this cycle (not full, or full with a pop)
module share_fifo #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             valid_o,
    output logic             accept_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    rptr_nxt;
    logic [AW:0]      cnt_q, cnt_d;
    logic [Width-1:0] head_q, head_d;
    logic             empty, full, do_pop, do_push;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW + 1)'(Depth));
    assign do_pop   = pop_i && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push_i && (!full || do_pop);
    assign rptr_nxt = rptr_q + AW'(1);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            head_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_nxt;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
                2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
            // Head tracks the oldest entry; a write into an empty (or emptying) FIFO
            // bypasses the array so the head is valid the cycle after the push.
            if (empty && do_push) begin
                head_d = wdata_i;
            end else if (do_pop) begin
                if (cnt_q >= (AW + 1)'(2)) begin
                    head_d = mem_q[rptr_nxt];
                end else if (do_push) begin
                    head_d = wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o  = head_q;
    assign valid_o  = !empty;
    assign accept_o = do_push && !flush_i;

endmodule

// File: rtl/nexus_share_filter.sv
// nexus_share_filter: matches Keccak output qwords against a share target and queues
// the nonces that produced them.
//   clk, nHashRst          - clock, asynchronous active-low reset
//   work_load, work_nonce  - new work strobe and its base nonce
//   target                 - share target, latched on work_load (hit: qword <= target)
//   hash_qword             - Keccak output qword, one per cycle once the pipe is full
//   nonce_out, nonce_valid,
//   nonce_ready            - winning-nonce FIFO head with valid/ready handshake
//   busy                   - pipeline filling after a work load
//   overflow               - sticky: a hit was dropped on a full FIFO
//   hit_count              - saturating count of accepted hits since the last load
module nexus_share_filter
    import nexus_pkg::*;
#(
    parameter int unsigned PIPE_LATENCY = PIPE_LATENCY_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        nHashRst,
    input  logic        work_load,
    input  logic [63:0] work_nonce,
    input  logic [63:0] target,
    input  logic [63:0] hash_qword,
    output logic [63:0] nonce_out,
    output logic        nonce_valid,
    input  logic        nonce_ready,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] hit_count
);

    localparam int unsigned CntW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    filt_state_t     state_q;
    logic [CntW-1:0] fill_cnt_q;
    nonce_t          cur_nonce_q;
    logic [63:0]     tgt_q;
    logic            overflow_q;
    logic [31:0]     hit_count_q;

    logic hit, push_req, push_acc;

    assign hit = (state_q == CHECK) && (hash_qword <= tgt_q);
    // A new load makes any in-flight hit stale.
    assign push_req = hit && !work_load;

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            state_q     <= IDLE;
            fill_cnt_q  <= '0;
            cur_nonce_q <= '0;
            tgt_q       <= '0;
            overflow_q  <= 1'b0;
            hit_count_q <= '0;
        end else if (work_load) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            cur_nonce_q <= work_nonce;
            tgt_q       <= target;
            overflow_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                FILL: begin
                    fill_cnt_q <= fill_cnt_q + CntW'(1);
                    if (fill_cnt_q == CntW'(PIPE_LATENCY - 1)) state_q <= CHECK;
                end
                CHECK: begin
                    cur_nonce_q <= cur_nonce_q + 64'd1;
                    if (push_req && !push_acc) overflow_q <= 1'b1;
                    if (push_acc && (hit_count_q != 32'hFFFF_FFFF)) begin
                        hit_count_q <= hit_count_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    share_fifo #(
        .Width (64),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .rst_ni   (nHashRst),
        .flush_i  (work_load),
        .push_i   (push_req),
        .wdata_i  (cur_nonce_q),
        .pop_i    (nonce_ready),
        .rdata_o  (nonce_out),
        .valid_o  (nonce_valid),
        .accept_o (push_acc)
    );

    assign busy      = (state_q == FILL);
    assign overflow  = overflow_q;
    assign hit_count = hit_count_q;

endmodule
